// File: rtl/vector_lane_packer.sv
// Packs a scalar (a, b) pair stream into N-lane vectors for a registered vector adder.
// Completed vectors issue with a one-cycle vec_valid strobe; y_valid/y_lanes trail by one
// cycle so they line up with the adder's registered output.
module vector_lane_packer #(
    parameter int unsigned W = 8,
    parameter int unsigned N = 4,
    localparam int unsigned CW = $clog2(N + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    input  logic          in_last,
    input  logic          stall,
    output logic [W-1:0]  a [N-1:0],
    output logic [W-1:0]  b [N-1:0],
    output logic          vec_valid,
    output logic [CW-1:0] vec_lanes,
    output logic          y_valid,
    output logic [CW-1:0] y_lanes
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [0:0] {StFill, StPending} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    fa_q [N-1:0];
    logic [W-1:0]    fa_d [N-1:0];
    logic [W-1:0]    fb_q [N-1:0];
    logic [W-1:0]    fb_d [N-1:0];
    logic [W-1:0]    a_q [N-1:0];
    logic [W-1:0]    a_d [N-1:0];
    logic [W-1:0]    b_q [N-1:0];
    logic [W-1:0]    b_d [N-1:0];
    logic [CW-1:0]   lanes_q, lanes_d;
    logic            vvalid_q;
    logic            yvalid_q;
    logic [CW-1:0]   ylanes_q;
    logic            accept;
    logic            issue;
    logic [CW-1:0]   issue_cnt;

    assign accept = in_valid && (state_q == StFill);

    // Fill/issue sequencing; the completing lane is written into fa_d/fb_d first, so an
    // immediate issue picks it up from there (bypass of in_a/in_b).
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        fa_d      = fa_q;
        fb_d      = fb_q;
        a_d       = a_q;
        b_d       = b_q;
        lanes_d   = lanes_q;
        issue     = 1'b0;
        issue_cnt = cnt_q;
        unique case (state_q)
            StFill: begin
                if (accept) begin
                    fa_d[idx_q] = in_a;
                    fb_d[idx_q] = in_b;
                    if (idx_q == IW'(N - 1) || in_last) begin
                        if (stall) begin
                            cnt_d   = CW'(idx_q) + CW'(1);
                            state_d = StPending;
                        end else begin
                            issue     = 1'b1;
                            issue_cnt = CW'(idx_q) + CW'(1);
                            idx_d     = '0;
                        end
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            StPending: begin
                if (!stall) begin
                    issue     = 1'b1;
                    issue_cnt = cnt_q;
                    idx_d     = '0;
                    state_d   = StFill;
                end
            end
            default: state_d = StFill;
        endcase
        // Lanes beyond the real count are zeroed so stale fill data never reaches the adder.
        if (issue) begin
            lanes_d = issue_cnt;
            for (int i = 0; i < int'(N); i++) begin
                a_d[i] = (i < int'(issue_cnt)) ? fa_d[i] : '0;
                b_d[i] = (i < int'(issue_cnt)) ? fb_d[i] : '0;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= StFill;
            idx_q    <= '0;
            cnt_q    <= '0;
            fa_q     <= '{default: '0};
            fb_q     <= '{default: '0};
            a_q      <= '{default: '0};
            b_q      <= '{default: '0};
            lanes_q  <= '0;
            vvalid_q <= 1'b0;
            yvalid_q <= 1'b0;
            ylanes_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            fa_q     <= fa_d;
            fb_q     <= fb_d;
            a_q      <= a_d;
            b_q      <= b_d;
            lanes_q  <= lanes_d;
            vvalid_q <= issue;
            yvalid_q <= vvalid_q;
            ylanes_q <= lanes_q;
        end
    end

    assign in_ready  = (state_q == StFill);
    assign a         = a_q;
    assign b         = b_q;
    assign vec_valid = vvalid_q;
    assign vec_lanes = lanes_q;
    assign y_valid   = yvalid_q;
    assign y_lanes   = ylanes_q;

endmodule

// File: tb/tb_vector_lane_packer.sv
// Self-checking bench for vector_lane_packer against a queue-based transaction model.
module tb_vector_lane_packer;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int CW = $clog2(N + 1);
    localparam int SW = 2 * N * W + 2 * CW + 3;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          stall = 1'b0;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          in_ready;
    logic [W-1:0]  a [N-1:0];
    logic [W-1:0]  b [N-1:0];
    logic          vec_valid;
    logic [CW-1:0] vec_lanes;
    logic          y_valid;
    logic [CW-1:0] y_lanes;

    int checks = 0;
    int failures = 0;

    // Model: pairs collected for the open vector, a pending flag, and last issued vector.
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    bit           m_pend = 0;
    logic [W-1:0] ma [N];
    logic [W-1:0] mb [N];
    int           m_lanes = 0;
    bit           m_valid = 0;
    bit           m_yv = 0;
    int           m_yl = 0;

    vector_lane_packer #(.W(W), .N(N)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_last  (in_last),
        .stall    (stall),
        .a        (a),
        .b        (b),
        .vec_valid(vec_valid),
        .vec_lanes(vec_lanes),
        .y_valid  (y_valid),
        .y_lanes  (y_lanes)
    );

    always #5 clock = ~clock;

    // Drive one cycle of inputs, advance the model across the edge, sample #1 after it.
    task automatic step(input bit rst_n, input bit v, input bit last, input bit st,
                        input logic [W-1:0] da, input logic [W-1:0] db);
        bit iss;
        reset = rst_n; in_valid = v; in_last = last; stall = st; in_a = da; in_b = db;
        iss = 0;
        if (!rst_n) begin
            qa.delete(); qb.delete();
            m_pend = 0; m_lanes = 0; m_valid = 0; m_yv = 0; m_yl = 0;
            for (int i = 0; i < N; i++) begin ma[i] = '0; mb[i] = '0; end
        end else begin
            m_yv = m_valid;
            m_yl = m_lanes;
            if (!m_pend) begin
                if (v) begin
                    qa.push_back(da);
                    qb.push_back(db);
                    if (qa.size() == N || last) begin
                        if (st) m_pend = 1;
                        else iss = 1;
                    end
                end
            end else if (!st) begin
                iss = 1;
            end
            m_valid = iss;
            if (iss) begin
                for (int i = 0; i < N; i++) begin
                    ma[i] = (i < qa.size()) ? qa[i] : '0;
                    mb[i] = (i < qb.size()) ? qb[i] : '0;
                end
                m_lanes = qa.size();
                qa.delete(); qb.delete();
                m_pend = 0;
            end
        end
        @(posedge clock);
        #1;
    endtask

    function automatic logic [SW-1:0] dut_state();
        logic [SW-1:0] s = '0;
        for (int i = 0; i < N; i++) begin
            s[i*W +: W]     = a[i];
            s[(N+i)*W +: W] = b[i];
        end
        s[2*N*W +: 2*CW+3] = {in_ready, vec_valid, vec_lanes, y_valid, y_lanes};
        return s;
    endfunction

    function automatic logic [SW-1:0] exp_state();
        logic [SW-1:0] s = '0;
        for (int i = 0; i < N; i++) begin
            s[i*W +: W]     = ma[i];
            s[(N+i)*W +: W] = mb[i];
        end
        s[2*N*W +: 2*CW+3] = {!m_pend, m_valid, CW'(m_lanes), m_yv, CW'(m_yl)};
        return s;
    endfunction

    task automatic test_reset();
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 8'h5a, 8'ha5);
        checks++;
        if (dut_state() !== {1'b1, {(SW-1){1'b0}}}) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", dut_state(), {1'b1, {(SW-1){1'b0}}});
        end
        step(1, 0, 0, 0, 0, 0);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_full_vector();
        logic [W-1:0] ea [N];
        for (int i = 0; i < N; i++) begin
            step(1, 1, 0, 0, W'(2 * i + 1), W'(2 * i + 2));
            checks++;
            if (dut_state() !== exp_state()) begin
                failures++;
                $display("FAIL full_vector cyc%0d got=%h exp=%h", i, dut_state(), exp_state());
            end
        end
        ea = '{8'd1, 8'd3, 8'd5, 8'd7};
        checks++;
        if (vec_valid !== 1'b1 || vec_lanes !== CW'(4) || a[0] !== ea[0] || a[3] !== ea[3]
            || b[3] !== 8'd8 || b[0] !== 8'd2) begin
            failures++;
            $display("FAIL full_vector_const got=v%b n%0d a3=%0d a0=%0d exp=v1 n4 a3=7 a0=1",
                     vec_valid, vec_lanes, a[3], a[0]);
        end
        step(1, 0, 0, 0, 0, 0);
        checks++;
        if (y_valid !== 1'b1 || y_lanes !== CW'(4) || vec_valid !== 1'b0) begin
            failures++;
            $display("FAIL full_vector_y got=yv%b yl%0d vv%b exp=yv1 yl4 vv0",
                     y_valid, y_lanes, vec_valid);
        end
    endtask

    task automatic test_early_close();
        step(1, 1, 0, 0, 8'd9, 8'd1);
        step(1, 1, 1, 0, 8'd9, 8'd2);
        checks++;
        if (dut_state() !== exp_state() || vec_lanes !== CW'(2) || a[2] !== 8'd0
            || b[1] !== 8'd2) begin
            failures++;
            $display("FAIL early_close got=%h exp=%h", dut_state(), exp_state());
        end
        step(1, 0, 0, 0, 0, 0);
        checks++;
        if (dut_state() !== exp_state() || y_lanes !== CW'(2)) begin
            failures++;
            $display("FAIL early_close_y got=%h exp=%h", dut_state(), exp_state());
        end
    endtask

    task automatic test_stall();
        int lows = 0;
        for (int i = 0; i < N + 2; i++) begin
            step(1, 1, 0, 1, W'($urandom), W'($urandom));
            if (!in_ready) lows++;
            checks++;
            if (dut_state() !== exp_state()) begin
                failures++;
                $display("FAIL stall_hold cyc%0d got=%h exp=%h", i, dut_state(), exp_state());
            end
        end
        checks++;
        if (lows != 3) begin
            failures++;
            $display("FAIL stall_ready_low got=%0d exp=3", lows);
        end
        step(1, 0, 0, 0, 0, 0);
        checks++;
        if (dut_state() !== exp_state() || vec_valid !== 1'b1 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_release got=%h exp=%h", dut_state(), exp_state());
        end
    endtask

    task automatic test_back_to_back();
        int strobes = 0;
        int last_t = -1;
        int gap_bad = 0;
        for (int i = 0; i < 3 * N + 2; i++) begin
            step(1, i < 3 * N, 0, 0, W'($urandom), W'($urandom));
            if (vec_valid) begin
                if (last_t >= 0 && i - last_t != N) gap_bad++;
                last_t = i;
                strobes++;
            end
            checks++;
            if (dut_state() !== exp_state()) begin
                failures++;
                $display("FAIL back_to_back cyc%0d got=%h exp=%h", i, dut_state(), exp_state());
            end
        end
        checks++;
        if (strobes != 3 || gap_bad != 0) begin
            failures++;
            $display("FAIL back_to_back_strobes got=%0d bad_gaps=%0d exp=3 bad_gaps=0",
                     strobes, gap_bad);
        end
    endtask

    task automatic test_reset_midfill(input bit in_pending);
        int n = in_pending ? N : 2;
        for (int i = 0; i < n; i++) step(1, 1, 0, in_pending, W'($urandom), W'($urandom));
        step(0, 0, 0, 0, 0, 0);
        checks++;
        if (dut_state() !== {1'b1, {(SW-1){1'b0}}}) begin
            failures++;
            $display("FAIL reset_mid p%0b got=%h exp=%h", in_pending, dut_state(),
                     {1'b1, {(SW-1){1'b0}}});
        end
        for (int i = 0; i < N + 2; i++) begin
            step(1, i < N, 0, 0, W'(8'h10 + i), W'(8'h20 + i));
            checks++;
            if (dut_state() !== exp_state()) begin
                failures++;
                $display("FAIL reset_mid_fresh p%0b cyc%0d got=%h exp=%h", in_pending, i,
                         dut_state(), exp_state());
            end
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < N + 2; i++) begin
            step(1, i < N, 0, 0, 8'd255, 8'd1);
            checks++;
            if (dut_state() !== exp_state()) begin
                failures++;
                $display("FAIL wrap cyc%0d got=%h exp=%h", i, dut_state(), exp_state());
            end
            if (vec_valid) begin
                checks++;
                if (W'(a[N-1] + b[N-1]) !== W'(0) || a[0] !== 8'd255) begin
                    failures++;
                    $display("FAIL wrap_sum got=a%0d+b%0d exp=255+1", a[N-1], b[N-1]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 79) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
                 W'($urandom), W'($urandom));
            checks++;
            if (dut_state() !== exp_state()) begin
                failures++;
                $display("FAIL random cyc%0d got=%h exp=%h", i, dut_state(), exp_state());
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_vector();
        test_early_close();
        test_stall();
        test_back_to_back();
        test_reset_midfill(0);
        test_reset_midfill(1);
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
